// File: rtl/fetch_mem_resp_if.sv
// fetch_mem_resp_if: fetch-unit request/response plus 16-bit memory read bus.
//   slave  : the fetch_mem_resp block (takes requests, drives the memory bus)
//   master : the fetch unit / memory side (drives requests, answers reads)
// Signals:
//   req, pc[19:0], bytefetch, inv       fetch request, byte/word select, cache invalidate
//   data[15:0], ack                     fetch result and its one-cycle valid pulse
//   mem_addr[18:0], mem_rd              word address and read strobe
//   mem_ack, mem_data[15:0]             read completion and little-endian data
interface fetch_mem_resp_if;
  logic        req;
  logic [19:0] pc;
  logic        bytefetch;
  logic        inv;
  logic [15:0] data;
  logic        ack;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport slave (
    input  req, pc, bytefetch, inv, mem_ack, mem_data,
    output data, ack, mem_addr, mem_rd
  );

  modport master (
    output req, pc, bytefetch, inv, mem_ack, mem_data,
    input  data, ack, mem_addr, mem_rd
  );
endinterface

// File: rtl/fetch_mem_resp.sv
// fetch_mem_resp: turns byte/word fetches at a 20-bit byte address into reads
// on a 16-bit word bus, with a one-entry word cache. Misaligned word fetches
// read two consecutive words (wrapping at the top of the 19-bit word space).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    fetch_mem_resp_if.slave (request, response and memory bus)
module fetch_mem_resp (
  input  logic               clk,
  input  logic               reset,
  fetch_mem_resp_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t      state_q, state_d;
  logic [19:0] pc_q, pc_d;
  logic        bf_q, bf_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] data_q, data_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] cword_q, cword_d;
  logic [18:0] ctag_q, ctag_d;
  logic        cvalid_q, cvalid_d;

  // Words needed by the latched fetch; w1 wraps 0x7FFFF -> 0x00000.
  logic [18:0] w0, w1;
  logic        mis;
  // Same decode on the incoming request, used for the IDLE decision.
  logic [18:0] in_w0;
  logic        in_mis, in_hit;
  logic [15:0] resp_data;

  assign w0     = pc_q[19:1];
  assign w1     = w0 + 19'd1;
  assign mis    = ~bf_q & pc_q[0];
  assign in_w0  = bus.pc[19:1];
  assign in_mis = ~bus.bytefetch & bus.pc[0];
  assign in_hit = cvalid_q && (ctag_q == in_w0);

  assign resp_data = bf_q ? {8'h00, (pc_q[0] ? lo_q[15:8] : lo_q[7:0])} :
                     mis  ? {hi_q[7:0], lo_q[15:8]} : lo_q;

  // Outputs decode straight from registered state; data and mem_addr keep
  // their last value through shadow registers when not being driven.
  assign bus.ack      = (state_q == RESP);
  assign bus.mem_rd   = (state_q == RD0) || (state_q == RD1);
  assign bus.mem_addr = (state_q == RD0) ? w0 : (state_q == RD1) ? w1 : addr_q;
  assign bus.data     = (state_q == RESP) ? resp_data : data_q;
  assign addr_d       = bus.mem_addr;
  assign data_d       = bus.data;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bf_d     = bf_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cword_d  = cword_q;
    ctag_d   = ctag_q;
    cvalid_d = cvalid_q;
    unique case (state_q)
      IDLE: if (bus.req) begin
        pc_d = bus.pc;
        bf_d = bus.bytefetch;
        if (in_hit) begin
          // Low word comes from the cache; a misaligned fetch still needs w1.
          lo_d    = cword_q;
          state_d = in_mis ? RD1 : RESP;
        end else begin
          state_d = RD0;
        end
      end
      RD0: if (bus.mem_ack) begin
        lo_d     = bus.mem_data;
        cword_d  = bus.mem_data;
        ctag_d   = w0;
        cvalid_d = 1'b1;
        state_d  = mis ? RD1 : RESP;
      end
      RD1: if (bus.mem_ack) begin
        hi_d     = bus.mem_data;
        cword_d  = bus.mem_data;
        ctag_d   = w1;
        cvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Invalidate beats a same-cycle cache load; the fetch itself still
    // completes with the bus data already captured in lo/hi.
    if (bus.inv) cvalid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      bf_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      cword_q  <= '0;
      ctag_q   <= '0;
      cvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bf_q     <= bf_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      cword_q  <= cword_d;
      ctag_q   <= ctag_d;
      cvalid_q <= cvalid_d;
    end
  end
endmodule
